operand_fwd_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the 16-bit 5-stage pipeline. Tracks destination registers of in-flight instructions (EX, MEM) and drives the select pair of both EX-stage operand muxes, each a 5-input 16-bit mux. Sources: in0 register file, in1 immediate, in2 EX/MEM result, in3 MEM/WB result, in4 PC. It also inserts a one-cycle stall plus EX bubble on load-use hazards, and honours pipeline hold and branch flush.

---
 rtl/cpu_ctrl_pkg.sv | 30 +++
 rtl/fwd_src_sel.sv | 50 +++++
 rtl/operand_fwd_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_operand_fwd_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared select encodings, operand kinds and FSM state for the operand forwarding controller
package cpu_ctrl_pkg;

    // Default register index width (16 architectural registers, r0 reads zero)
    localparam int REG_ADDR_W_DEF = 4;

    // Operand mux select pair: top picks immediate, bottom picks among the rest
    typedef struct packed {
        logic       top;
        logic [1:0] bot;
    } sel_t;

    localparam sel_t SEL_REG       = '{top: 1'b0, bot: 2'b11};
    localparam sel_t SEL_IMM       = '{top: 1'b1, bot: 2'b11};
    localparam sel_t SEL_FWD_EXMEM = '{top: 1'b0, bot: 2'b00};
    localparam sel_t SEL_FWD_MEMWB = '{top: 1'b0, bot: 2'b01};
    localparam sel_t SEL_PC        = '{top: 1'b0, bot: 2'b10};

    // Operand kind as decoded in ID; the reserved code behaves as a register read
    localparam logic [1:0] KIND_REG = 2'b00;
    localparam logic [1:0] KIND_IMM = 2'b01;
    localparam logic [1:0] KIND_PC  = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } fwd_state_e;

endpackage

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - priority resolver choosing the EX operand source for one operand
module fwd_src_sel
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid,
    input  logic [1:0]            src,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  ex_wr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  mem_wr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  sel_top,
    output logic [1:0]            sel_bot,
    output logic                  lu_hit
);

    sel_t sel;

    // PC and immediate win outright; register reads check r0, then the
    // youngest in-flight writer, then the older one, else the register file.
    // A register read that hits a load still in EX cannot be forwarded yet.
    always_comb begin
        sel    = SEL_REG;
        lu_hit = 1'b0;
        case (src)
            KIND_PC:  sel = SEL_PC;
            KIND_IMM: sel = SEL_IMM;
            default: begin
                // KIND_REG and KIND_RSV
                if (rs == '0) begin
                    sel = SEL_REG;
                end else if (ex_wr && (rs == ex_rd)) begin
                    sel    = SEL_FWD_EXMEM;
                    lu_hit = id_valid & ex_is_load;
                end else if (mem_wr && (rs == mem_rd)) begin
                    sel = SEL_FWD_MEMWB;
                end else begin
                    sel = SEL_REG;
                end
            end
        endcase
    end

    assign sel_top = sel.top;
    assign sel_bot = sel.bot;

endmodule

// File: rtl/operand_fwd_ctrl.sv
// rtl/operand_fwd_ctrl.sv - EX operand forwarding and load-use stall controller (OPERAND_FWD_STALL_CNT_EN adds stall counter)
module operand_fwd_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_a,
    input  logic [REG_ADDR_W-1:0] id_rs_b,
    input  logic [1:0]            id_a_src,
    input  logic [1:0]            id_b_src,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    output logic                  stall,
    output logic                  ex_bubble,
    output logic                  sel_a_top,
    output logic                  sel_b_top,
    output logic [1:0]            sel_a_bot,
    output logic [1:0]            sel_b_bot,
    output logic [CNT_W-1:0]      stall_count
);

    // In-flight destination tracking
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_we;
    logic                  ex_is_load;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_we;

    logic                  ex_wr;
    logic                  mem_wr;

    logic                  a_top_d;
    logic [1:0]            a_bot_d;
    logic                  a_lu_hit;
    logic                  b_top_d;
    logic [1:0]            b_bot_d;
    logic                  b_lu_hit;

    logic                  ex_load_bubble;

    fwd_state_e            state;
    fwd_state_e            state_nxt;

    // Only real register writes (valid, enabled, not r0) can be forwarded
    assign ex_wr  = ex_valid  & ex_we  & (ex_rd  != '0);
    assign mem_wr = mem_valid & mem_we & (mem_rd != '0);

    fwd_src_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sel_a (
        .id_valid   (id_valid),
        .src        (id_a_src),
        .rs         (id_rs_a),
        .ex_wr      (ex_wr),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .sel_top    (a_top_d),
        .sel_bot    (a_bot_d),
        .lu_hit     (a_lu_hit)
    );

    fwd_src_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sel_b (
        .id_valid   (id_valid),
        .src        (id_b_src),
        .rs         (id_rs_b),
        .ex_wr      (ex_wr),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .sel_top    (b_top_d),
        .sel_bot    (b_bot_d),
        .lu_hit     (b_lu_hit)
    );

    // A branch flush kills the dependent instruction, so it must not stall;
    // after one stall cycle the load sits in MEM and the hit cannot recur
    assign stall = (a_lu_hit | b_lu_hit) & ~flush & (state == ST_RUN);

    // ID instruction enters EX as a bubble when killed, stalled or absent
    assign ex_load_bubble = flush | stall | ~id_valid;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: hold freezes, flush returns to RUN, a stall lasts one cycle
    always_comb begin
        state_nxt = state;
        if (!hold) begin
            if (flush) begin
                state_nxt = ST_RUN;
            end else begin
                case (state)
                    ST_RUN:      state_nxt = stall ? ST_LU_STALL : ST_RUN;
                    ST_LU_STALL: state_nxt = ST_RUN;
                    default:     state_nxt = ST_RUN;
                endcase
            end
        end
    end

    // Advance the EX/MEM tracking entries each unheld cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            ex_is_load <= 1'b0;
            mem_valid  <= 1'b0;
            mem_rd     <= '0;
            mem_we     <= 1'b0;
        end else if (!hold) begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            if (ex_load_bubble) begin
                ex_valid   <= 1'b0;
                ex_rd      <= '0;
                ex_we      <= 1'b0;
                ex_is_load <= 1'b0;
            end else begin
                ex_valid   <= 1'b1;
                ex_rd      <= id_rd;
                ex_we      <= id_we;
                ex_is_load <= id_is_load;
            end
        end
    end

    // Register the ID-stage select decision for use while the instruction is in EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_top <= SEL_REG.top;
            sel_a_bot <= SEL_REG.bot;
            sel_b_top <= SEL_REG.top;
            sel_b_bot <= SEL_REG.bot;
            ex_bubble <= 1'b1;
        end else if (!hold) begin
            if (ex_load_bubble) begin
                sel_a_top <= SEL_REG.top;
                sel_a_bot <= SEL_REG.bot;
                sel_b_top <= SEL_REG.top;
                sel_b_bot <= SEL_REG.bot;
                ex_bubble <= 1'b1;
            end else begin
                sel_a_top <= a_top_d;
                sel_a_bot <= a_bot_d;
                sel_b_top <= b_top_d;
                sel_b_bot <= b_bot_d;
                ex_bubble <= 1'b0;
            end
        end
    end

`ifdef OPERAND_FWD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of unheld stall cycles, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && !hold && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// tb/tb_operand_fwd_ctrl.sv - directed vector bench for operand_fwd_ctrl
module tb_operand_fwd_ctrl;

    localparam logic [1:0] KR = 2'b00;
    localparam logic [1:0] KI = 2'b01;
    localparam logic [1:0] KP = 2'b10;
    localparam logic [1:0] KX = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_rs_a;
    logic [3:0]  id_rs_b;
    logic [1:0]  id_a_src;
    logic [1:0]  id_b_src;
    logic [3:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        stall;
    logic        ex_bubble;
    logic        sel_a_top;
    logic        sel_b_top;
    logic [1:0]  sel_a_bot;
    logic [1:0]  sel_b_bot;
    logic [15:0] stall_count;

    int          n_vec;
    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_cnt;

    typedef struct {
        logic       hold;
        logic       flush;
        logic       v;
        logic [3:0] rsa;
        logic [3:0] rsb;
        logic [1:0] asrc;
        logic [1:0] bsrc;
        logic [3:0] rd;
        logic       we;
        logic       ld;
        logic       st;
        logic       cs;
        logic       at;
        logic [1:0] ab;
        logic       bt;
        logic [1:0] bb;
        logic       bub;
    } vec_t;

    vec_t tbl[17];

    operand_fwd_ctrl #(
        .REG_ADDR_W (4),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rs_a     (id_rs_a),
        .id_rs_b     (id_rs_b),
        .id_a_src    (id_a_src),
        .id_b_src    (id_b_src),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .stall       (stall),
        .ex_bubble   (ex_bubble),
        .sel_a_top   (sel_a_top),
        .sel_b_top   (sel_b_top),
        .sel_a_bot   (sel_a_bot),
        .sel_b_bot   (sel_b_bot),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic h, input logic f, input logic v,
                                input logic [3:0] rsa, input logic [3:0] rsb,
                                input logic [1:0] asrc, input logic [1:0] bsrc,
                                input logic [3:0] rd, input logic we, input logic ld,
                                input logic st, input logic cs,
                                input logic at, input logic [1:0] ab,
                                input logic bt, input logic [1:0] bb,
                                input logic bub);
        vec_t t;
        t.hold = h;   t.flush = f;  t.v = v;
        t.rsa = rsa;  t.rsb = rsb;  t.asrc = asrc; t.bsrc = bsrc;
        t.rd = rd;    t.we = we;    t.ld = ld;
        t.st = st;    t.cs = cs;
        t.at = at;    t.ab = ab;    t.bt = bt;     t.bb = bb;
        t.bub = bub;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " sel_a_top"}, {31'd0, sel_a_top}, 32'd0);
        chk({tag, " sel_a_bot"}, {30'd0, sel_a_bot}, 32'd3);
        chk({tag, " sel_b_top"}, {31'd0, sel_b_top}, 32'd0);
        chk({tag, " sel_b_bot"}, {30'd0, sel_b_bot}, 32'd3);
        chk({tag, " ex_bubble"}, {31'd0, ex_bubble}, 32'd1);
        chk({tag, " stall"}, {31'd0, stall}, 32'd0);
        chk({tag, " stall_count"}, {16'd0, stall_count}, 32'd0);
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        hold       = t.hold;
        flush      = t.flush;
        id_valid   = t.v;
        id_rs_a    = t.rsa;
        id_rs_b    = t.rsb;
        id_a_src   = t.asrc;
        id_b_src   = t.bsrc;
        id_rd      = t.rd;
        id_we      = t.we;
        id_is_load = t.ld;
        #1;
        chk({tag, " stall"}, {31'd0, stall}, {31'd0, t.st});
        @(posedge clk);
        #1;
`ifdef OPERAND_FWD_STALL_CNT_EN
        if (t.st && !t.hold && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
`endif
        if (t.cs) begin
            chk({tag, " sel_a_top"}, {31'd0, sel_a_top}, {31'd0, t.at});
            chk({tag, " sel_a_bot"}, {30'd0, sel_a_bot}, {30'd0, t.ab});
            chk({tag, " sel_b_top"}, {31'd0, sel_b_top}, {31'd0, t.bt});
            chk({tag, " sel_b_bot"}, {30'd0, sel_b_bot}, {30'd0, t.bb});
        end
        chk({tag, " ex_bubble"}, {31'd0, ex_bubble}, {31'd0, t.bub});
        chk({tag, " stall_count"}, {16'd0, stall_count}, {16'd0, exp_cnt});
        n_vec++;
    endtask

    initial begin
        n_vec = 0; n_cmp = 0; n_fail = 0; exp_cnt = 16'd0;
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs_a = '0; id_rs_b = '0; id_a_src = KR; id_b_src = KR;
        id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;

        //          h f v  rsa rsb asrc bsrc rd we ld  st cs  at ab bt bb bub
        tbl[0]  = mk(0,0,1,  1,  2, KR, KR,  3, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[1]  = mk(0,0,1,  3,  4, KR, KR,  6, 1, 0,  0, 1,  0, 0, 0, 3, 0);
        tbl[2]  = mk(0,0,1,  0,  0, KR, KR,  7, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[3]  = mk(0,0,1,  1,  2, KR, KR,  8, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[4]  = mk(0,0,1,  1,  7, KR, KR,  9, 0, 0,  0, 1,  0, 3, 0, 1, 0);
        tbl[5]  = mk(0,0,1,  2,  2, KR, KR,  2, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[6]  = mk(0,0,1,  2,  2, KR, KR,  2, 1, 0,  0, 1,  0, 0, 0, 0, 0);
        tbl[7]  = mk(0,0,1,  2,  5, KR, KR,  4, 1, 0,  0, 1,  0, 0, 0, 3, 0);
        tbl[8]  = mk(0,0,1,  1,  1, KR, KR,  0, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[9]  = mk(0,0,1,  0,  0, KR, KR, 10, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[10] = mk(0,0,1, 10, 10, KP, KI, 11, 1, 0,  0, 1,  0, 2, 1, 3, 0);
        tbl[11] = mk(0,0,1, 11,  3, KX, KR,  0, 0, 0,  0, 1,  0, 0, 0, 3, 0);
        tbl[12] = mk(0,0,0,  0,  0, KR, KR, 12, 1, 0,  0, 1,  0, 3, 0, 3, 1);
        tbl[13] = mk(0,0,1, 12, 12, KR, KR, 13, 0, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[14] = mk(0,0,1, 13, 12, KR, KR, 14, 1, 0,  0, 1,  0, 3, 0, 3, 0);
        tbl[15] = mk(0,0,1, 14, 14, KI, KR,  1, 1, 1,  0, 1,  1, 3, 0, 0, 0);
        tbl[16] = mk(0,0,1,  1,  1, KI, KP,  2, 0, 0,  0, 1,  1, 3, 0, 2, 0);

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Load-use: one stall, a bubble, then MEM/WB forward
        apply(mk(0,0,1, 0, 0, KR, KR, 5, 1, 1,  0, 1, 0, 3, 0, 3, 0), "lu0");
        apply(mk(0,0,1, 1, 5, KR, KR, 6, 1, 0,  1, 0, 0, 3, 0, 3, 1), "lu1");
        apply(mk(0,0,1, 1, 5, KR, KR, 6, 1, 0,  0, 1, 0, 3, 0, 1, 0), "lu2");

        // Flush on a load-use cycle: no stall, bubble, back to normal flow
        apply(mk(0,0,1, 0, 0, KR, KR, 5, 1, 1,  0, 1, 0, 3, 0, 3, 0), "fl0");
        apply(mk(0,1,1, 0, 5, KR, KR, 6, 1, 0,  0, 1, 0, 3, 0, 3, 1), "fl1");
        apply(mk(0,0,1, 1, 2, KR, KR, 7, 1, 0,  0, 1, 0, 3, 0, 3, 0), "fl2");

        // Hold during load-use freezes outputs and the counter
        apply(mk(0,0,1, 0, 0, KR, KR, 9, 1, 1,  0, 1, 0, 3, 0, 3, 0), "hd0");
        apply(mk(1,0,1, 0, 9, KR, KR,10, 1, 0,  1, 1, 0, 3, 0, 3, 0), "hd1");
        apply(mk(0,0,1, 0, 9, KR, KR,10, 1, 0,  1, 0, 0, 3, 0, 3, 1), "hd2");
        apply(mk(0,0,1, 0, 9, KR, KR,10, 1, 0,  0, 1, 0, 3, 0, 1, 0), "hd3");
        apply(mk(1,1,1,10, 9, KR, KR,11, 1, 1,  0, 1, 0, 3, 0, 1, 0), "hd4");
        apply(mk(0,0,1,10, 0, KR, KR,12, 1, 0,  0, 1, 0, 0, 0, 3, 0), "hd5");

        // Asynchronous reset mid-stream while a load-use is pending
        apply(mk(0,0,1, 0, 0, KR, KR, 4, 1, 1,  0, 1, 0, 3, 0, 3, 0), "rs0");
        @(negedge clk);
        id_valid = 1'b1; id_rs_a = 4'd4; id_a_src = KR; id_is_load = 1'b0;
        #1;
        chk("rs_pre stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        check_reset_vals("rs_mid");
        @(negedge clk);
        id_valid = 1'b0;
        rst_n = 1'b1;
        apply(mk(0,0,1, 4, 4, KR, KR, 5, 1, 0,  0, 1, 0, 3, 0, 3, 0), "rs1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
